time_counter: RTL and testbench

TIME_COUNTER -- requirements
Module: time_counter

---
 rtl/time_counter.sv | 191 +++++++++++++++++++
 tb/tb_time_counter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_counter.sv
// ---------------------------------------------------------------------------
// time_counter
//
// Time-of-day counter with hundredths-of-a-second resolution, presented as
// eight packed BCD digits for a downstream hex/7-segment display stage.
//
// A prescaler divides the input clock down to TICK_HZ. Every tick advances
// the hundredths field, which ripples carries through seconds, minutes and
// hours (00:00:00.00 .. 23:59:59.99). Fields are also user-adjustable one
// step per cycle without carrying into the next field.
//
// Parameters
//   CLK_HZ   input clock frequency in Hz
//   TICK_HZ  counting rate in Hz (100 = hundredths). CLK_HZ/TICK_HZ must be
//            an integer >= 2.
//
// Ports
//   clk100MHz  in   1   sole clock, all state on the rising edge
//   reset_n    in   1   asynchronous active-low reset
//   run        in   1   count enable; 0 freezes time and the prescaler
//   clear      in   1   synchronous zero of time and prescaler
//   adj_valid  in   1   increment the field chosen by adj_field this cycle
//   adj_field  in   2   0 seconds, 1 minutes, 2 hours, 3 ignored
//   data       out  32  {hh, mm, ss, cc} as packed BCD, two digits each
//   sec_pulse  out  1   one-cycle pulse when seconds advance by carry
//   day_wrap   out  1   one-cycle pulse on 23:59:59.99 -> 00:00:00.00
//
// Priority within one cycle: clear > adjust > tick. A tick that lands on a
// clear or a valid adjust is dropped, not remembered.
// ---------------------------------------------------------------------------
module time_counter #(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = 100
) (
    input  logic        clk100MHz,
    input  logic        reset_n,
    input  logic        run,
    input  logic        clear,
    input  logic        adj_valid,
    input  logic [1:0]  adj_field,
    output logic [31:0] data,
    output logic        sec_pulse,
    output logic        day_wrap
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    localparam logic [1:0] FIELD_SEC  = 2'd0;
    localparam logic [1:0] FIELD_MIN  = 2'd1;
    localparam logic [1:0] FIELD_HOUR = 2'd2;

    // Last legal value of each two-digit BCD field.
    localparam logic [7:0] CC_LAST = 8'h99;
    localparam logic [7:0] SS_LAST = 8'h59;
    localparam logic [7:0] MM_LAST = 8'h59;
    localparam logic [7:0] HH_LAST = 8'h23;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    cc_q, cc_d;     // hundredths
    logic [7:0]    ss_q, ss_d;     // seconds
    logic [7:0]    mm_q, mm_d;     // minutes
    logic [7:0]    hh_q, hh_d;     // hours
    logic          sec_pulse_q, sec_pulse_d;
    logic          day_wrap_q, day_wrap_d;

    // -----------------------------------------------------------------------
    // Two-digit BCD increment that wraps to 00 after `last`. Operating on the
    // digits directly keeps every digit in 0..9; there is never a binary
    // intermediate that could leak onto data.
    // -----------------------------------------------------------------------
    function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                           input logic [7:0] last);
        logic [7:0] r;
        if (v == last) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // Prescaler and tick
    // -----------------------------------------------------------------------
    logic          tick;
    logic [PW-1:0] presc_next;

    always_comb begin
        tick       = run && (presc_q == PRESC_LAST);
        presc_next = presc_q;
        if (run) begin
            // Held (not cleared) while run is low so a paused count resumes
            // exactly where it stopped.
            presc_next = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
        end
    end

    // Field 3 is reserved: treated as if no adjust request was made, so it
    // neither changes state nor suppresses a coinciding tick.
    logic adj_do;
    assign adj_do = adj_valid && (adj_field != 2'd3);

    // -----------------------------------------------------------------------
    // Next-state logic: clear > adjust > tick
    // -----------------------------------------------------------------------
    always_comb begin
        presc_d     = presc_next;
        cc_d        = cc_q;
        ss_d        = ss_q;
        mm_d        = mm_q;
        hh_d        = hh_q;
        sec_pulse_d = 1'b0;
        day_wrap_d  = 1'b0;

        if (clear) begin
            presc_d = '0;
            cc_d    = 8'h00;
            ss_d    = 8'h00;
            mm_d    = 8'h00;
            hh_d    = 8'h00;
        end else if (adj_do) begin
            // Adjusts never carry into a higher field. A tick landing here
            // is dropped; the prescaler still advances/wraps normally except
            // on a seconds adjust, which restarts the current second cleanly.
            case (adj_field)
                FIELD_SEC: begin
                    ss_d    = bcd_inc(ss_q, SS_LAST);
                    cc_d    = 8'h00;
                    presc_d = '0;
                end
                FIELD_MIN:  mm_d = bcd_inc(mm_q, MM_LAST);
                FIELD_HOUR: hh_d = bcd_inc(hh_q, HH_LAST);
                default:    ;
            endcase
        end else if (tick) begin
            cc_d = bcd_inc(cc_q, CC_LAST);
            if (cc_q == CC_LAST) begin
                ss_d        = bcd_inc(ss_q, SS_LAST);
                sec_pulse_d = 1'b1;
                if (ss_q == SS_LAST) begin
                    mm_d = bcd_inc(mm_q, MM_LAST);
                    if (mm_q == MM_LAST) begin
                        hh_d = bcd_inc(hh_q, HH_LAST);
                        // Hours 23 -> 00 ends the day; nothing above it.
                        if (hh_q == HH_LAST) begin
                            day_wrap_d = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registers. Reset is asynchronous, so data and the pulses go to zero
    // immediately and any in-flight carry or adjust is lost.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk100MHz or negedge reset_n) begin
        if (!reset_n) begin
            presc_q     <= '0;
            cc_q        <= 8'h00;
            ss_q        <= 8'h00;
            mm_q        <= 8'h00;
            hh_q        <= 8'h00;
            sec_pulse_q <= 1'b0;
            day_wrap_q  <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            cc_q        <= cc_d;
            ss_q        <= ss_d;
            mm_q        <= mm_d;
            hh_q        <= hh_d;
            sec_pulse_q <= sec_pulse_d;
            day_wrap_q  <= day_wrap_d;
        end
    end

    // Outputs come straight from flops: data changes in the same cycle the
    // pulses assert, one cycle after the tick cycle.
    assign data      = {hh_q, mm_q, ss_q, cc_q};
    assign sec_pulse = sec_pulse_q;
    assign day_wrap  = day_wrap_q;

endmodule

// File: tb/tb_time_counter.sv
// ---------------------------------------------------------------------------
// tb_time_counter
//
// Directed bench for time_counter with CLK_HZ=10, TICK_HZ=1 (DIV=10).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. they reflect the edge just taken.
// ---------------------------------------------------------------------------
module tb_time_counter;

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    logic        clk100MHz;
    logic        reset_n;
    logic        run;
    logic        clear;
    logic        adj_valid;
    logic [1:0]  adj_field;
    logic [31:0] data;
    logic        sec_pulse;
    logic        day_wrap;

    initial clk100MHz = 1'b0;
    always #5 clk100MHz = ~clk100MHz;

    time_counter #(
        .CLK_HZ  (10),
        .TICK_HZ (1)
    ) dut (
        .clk100MHz (clk100MHz),
        .reset_n   (reset_n),
        .run       (run),
        .clear     (clear),
        .adj_valid (adj_valid),
        .adj_field (adj_field),
        .data      (data),
        .sec_pulse (sec_pulse),
        .day_wrap  (day_wrap)
    );

    // -----------------------------------------------------------------------
    // Scoreboard state
    // -----------------------------------------------------------------------
    int          n_checks = 0;
    int          n_pass   = 0;
    int          sec_cnt  = 0;   // sec_pulse cycles seen since start
    int          day_cnt  = 0;   // day_wrap cycles seen since start
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------------
    task automatic step();
        @(posedge clk100MHz);
        #1;
        if (sec_pulse === 1'b1) sec_cnt++;
        if (day_wrap === 1'b1)  day_cnt++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drive(input logic r, input logic c, input logic av,
                         input logic [1:0] af);
        run       = r;
        clear     = c;
        adj_valid = av;
        adj_field = af;
    endtask

    // Hold adj_valid for n cycles: one increment per cycle.
    task automatic adj_n(input logic [1:0] field, input int n);
        adj_valid = 1'b1;
        adj_field = field;
        steps(n);
        adj_valid = 1'b0;
        adj_field = 2'd0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    // Vector table
    // -----------------------------------------------------------------------
    typedef struct {
        logic        run;
        logic        clear;
        logic        adj_valid;
        logic [1:0]  adj_field;
        logic [31:0] exp_data;
        logic        exp_sec;
        logic        exp_day;
    } vec_t;

    vec_t vecs[10];

    // -----------------------------------------------------------------------
    // Test
    // -----------------------------------------------------------------------
    initial begin
        int sc0;
        int dc0;
        int changes;
        logic [31:0] ref_data;

        // Single-cycle vectors with run=0 (no ticks): adjust, reserved
        // field, idle and clear priority.
        vecs[0] = '{1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_0000, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h0000_0100, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 2'd1, 32'h0001_0100, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 2'd2, 32'h0101_0100, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 2'd3, 32'h0101_0100, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h0101_0100, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h0101_0200, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 2'd2, 32'h0000_0000, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 2'd2, 32'h0100_0000, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_0000, 1'b0, 1'b0};

        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'd0);
        steps(2);

        // Reset state.
        check("reset_data", data, 32'h0000_0000);
        check("reset_sec_pulse", {31'd0, sec_pulse}, 32'd0);
        check("reset_day_wrap", {31'd0, day_wrap}, 32'd0);

        // Release reset and count 25 cycles: ticks at cycles 10 and 20.
        reset_n = 1'b1;
        run     = 1'b1;
        sc0 = sec_cnt;
        dc0 = day_cnt;
        for (int i = 1; i <= 25; i++) begin
            step();
            check($sformatf("count25_cyc%0d", i), data, 32'(i / 10));
        end
        check("count25_final", data, 32'h0000_0002);
        check("count25_no_sec", 32'(sec_cnt - sc0), 32'd0);
        check("count25_no_day", 32'(day_cnt - dc0), 32'd0);

        // Table-driven single-cycle vectors.
        run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].run, vecs[i].clear, vecs[i].adj_valid,
                  vecs[i].adj_field);
            exp_q.push_back(vecs[i].exp_data);
            step();
            check($sformatf("vec%0d_data", i), data, exp_q.pop_front());
            check($sformatf("vec%0d_sec", i), {31'd0, sec_pulse},
                  {31'd0, vecs[i].exp_sec});
            check($sformatf("vec%0d_day", i), {31'd0, day_wrap},
                  {31'd0, vecs[i].exp_day});
        end
        drive(1'b0, 1'b0, 1'b0, 2'd0);

        // 00:00:59.99 -> 00:01:00.00 with a single sec_pulse.
        do_clear();
        sc0 = sec_cnt;
        adj_n(2'd0, 59);
        check("preload_59s", data, 32'h0000_5900);
        check("adjust_no_sec_pulse", 32'(sec_cnt - sc0), 32'd0);
        run = 1'b1;
        steps(999);
        check("at_59_99", data, 32'h0000_5999);
        check("no_pulse_before_carry", 32'(sec_cnt - sc0), 32'd0);
        step();
        check("min_carry_data", data, 32'h0001_0000);
        check("min_carry_sec", {31'd0, sec_pulse}, 32'd1);
        check("min_carry_day", {31'd0, day_wrap}, 32'd0);
        step();
        check("min_carry_sec_drop", {31'd0, sec_pulse}, 32'd0);
        check("min_carry_hold", data, 32'h0001_0000);

        // 23:59:59.99 -> 00:00:00.00 with sec_pulse and day_wrap together.
        run = 1'b0;
        do_clear();
        adj_n(2'd2, 23);
        adj_n(2'd1, 59);
        adj_n(2'd0, 59);
        check("preload_23_59_59", data, 32'h2359_5900);
        run = 1'b1;
        steps(999);
        check("at_23_59_59_99", data, 32'h2359_5999);
        step();
        check("day_wrap_data", data, 32'h0000_0000);
        check("day_wrap_sec", {31'd0, sec_pulse}, 32'd1);
        check("day_wrap_day", {31'd0, day_wrap}, 32'd1);
        step();
        check("day_wrap_pulses_drop", {30'd0, sec_pulse, day_wrap}, 32'd0);

        // Minute adjust wraps without carrying; reserved field is a no-op.
        run = 1'b0;
        do_clear();
        sc0 = sec_cnt;
        dc0 = day_cnt;
        adj_n(2'd1, 59);
        check("adj_min_59", data, 32'h0059_0000);
        adj_n(2'd2, 1);
        check("adj_hour_01", data, 32'h0159_0000);
        adj_n(2'd1, 1);
        check("adj_min_wrap_no_carry", data, 32'h0100_0000);
        adj_n(2'd3, 1);
        check("adj_reserved", data, 32'h0100_0000);
        adj_n(2'd2, 23);
        check("adj_hour_wrap", data, 32'h0000_0000);
        check("adj_no_pulses", 32'((sec_cnt - sc0) + (day_cnt - dc0)), 32'd0);

        // Seconds adjust zeroes hundredths and restarts the prescaler.
        do_clear();
        run = 1'b1;
        steps(35);
        check("run35", data, 32'h0000_0003);
        adj_n(2'd0, 1);
        check("sec_adj_zero_cc", data, 32'h0000_0100);
        steps(9);
        check("sec_adj_presc_9", data, 32'h0000_0100);
        step();
        check("sec_adj_presc_10", data, 32'h0000_0101);

        // clear + adjust + tick in the same cycle.
        run = 1'b0;
        do_clear();
        run = 1'b1;
        steps(19);
        check("pre_collide", data, 32'h0000_0001);
        drive(1'b1, 1'b1, 1'b1, 2'd0);
        step();
        check("collide_data", data, 32'h0000_0000);
        check("collide_pulses", {30'd0, sec_pulse, day_wrap}, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 2'd0);
        steps(9);
        check("after_clear_9", data, 32'h0000_0000);
        step();
        check("after_clear_10", data, 32'h0000_0001);

        // Adjust coinciding with a tick drops the tick for good.
        steps(9);
        adj_n(2'd1, 1);
        check("adj_tick_collide", data, 32'h0001_0001);
        step();
        check("tick_not_deferred", data, 32'h0001_0001);

        // run=0 freezes time and holds the prescaler.
        run = 1'b0;
        do_clear();
        run = 1'b1;
        steps(14);
        check("pre_pause", data, 32'h0000_0001);
        run = 1'b0;
        changes  = 0;
        ref_data = data;
        for (int i = 0; i < 50; i++) begin
            step();
            if (data !== ref_data) changes++;
        end
        check("pause_changes", 32'(changes), 32'd0);
        check("pause_data", data, 32'h0000_0001);
        run = 1'b1;
        steps(5);
        check("resume_5", data, 32'h0000_0001);
        step();
        check("resume_6", data, 32'h0000_0002);

        // Asynchronous reset between edges, with an adjust pending.
        steps(3);
        @(posedge clk100MHz);
        #3;
        adj_valid = 1'b1;
        adj_field = 2'd2;
        reset_n   = 1'b0;
        #1;
        check("async_reset_data", data, 32'h0000_0000);
        check("async_reset_pulses", {30'd0, sec_pulse, day_wrap}, 32'd0);
        step();
        check("reset_held_adj_dropped", data, 32'h0000_0000);
        reset_n   = 1'b1;
        adj_valid = 1'b0;
        adj_field = 2'd0;
        steps(9);
        check("post_reset_9", data, 32'h0000_0000);
        step();
        check("post_reset_10", data, 32'h0000_0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
